// File: rtl/mips_dmem_rmw_ctrl_if.sv
// CPU data port and data-RAM port of the MIPS data-memory read-modify-write controller.
// The slave modport is the controller; the master modport is the CPU/RAM side.
interface mips_dmem_rmw_ctrl_if;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata, mem_readdata,
    output cpu_readdata, cpu_stall, mem_address, mem_read, mem_write, mem_writedata
  );

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata, mem_readdata,
    input  cpu_readdata, cpu_stall, mem_address, mem_read, mem_write, mem_writedata
  );
endinterface

// File: rtl/mips_dmem_rmw_ctrl.sv
// Data-memory controller: byte-swaps between register and memory order and turns
// partial stores into a 3-cycle read-modify-write against a word-only RAM.
module mips_dmem_rmw_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  mips_dmem_rmw_ctrl_if.slave   bus,
  output logic                  align_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RMW_RD = 2'b01,
    RMW_WR = 2'b10
  } state_t;

  function automatic logic [31:0] swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_t      state, next_state;
  logic [31:0] rmw_buf;
  logic [31:0] merged;
  logic [31:0] merge_word;
  logic [31:0] old_reg;
  logic [31:2] lat_addr;
  logic [3:0]  lat_be;
  logic [31:0] lat_wd;
  logic        capture;
  logic        fsm_read, fsm_write, fsm_stall;
  logic [31:0] addr_out, wdata_out;
  logic        wr_req, rd_req, be_full, be_none;

  assign wr_req  = bus.cpu_write;
  assign rd_req  = bus.cpu_read & ~bus.cpu_write;
  assign be_full = (bus.cpu_byteenable == 4'b1111);
  assign be_none = (bus.cpu_byteenable == 4'b0000);

  always_comb begin
    old_reg    = swap(rmw_buf);
    merge_word = old_reg;
    for (int i = 0; i < 4; i++) begin
      if (lat_be[i]) merge_word[8*i +: 8] = lat_wd[8*i +: 8];
    end
  end

  always_comb begin
    next_state = state;
    fsm_read   = 1'b0;
    fsm_write  = 1'b0;
    fsm_stall  = 1'b0;
    capture    = 1'b0;
    addr_out   = {bus.cpu_address[31:2], 2'b00};
    wdata_out  = swap(bus.cpu_writedata);
    case (state)
      IDLE: begin
        if (wr_req) begin
          if (be_full) begin
            fsm_write = 1'b1;
          end else if (!be_none) begin
            fsm_read   = 1'b1;
            fsm_stall  = 1'b1;
            capture    = 1'b1;
            next_state = RMW_RD;
          end
        end else if (rd_req) begin
          fsm_read = 1'b1;
        end
      end
      RMW_RD: begin
        fsm_stall  = 1'b1;
        addr_out   = {lat_addr, 2'b00};
        next_state = RMW_WR;
      end
      RMW_WR: begin
        fsm_write  = 1'b1;
        addr_out   = {lat_addr, 2'b00};
        wdata_out  = swap(merged);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Store operands are latched in IDLE so the CPU may change its inputs mid-RMW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rmw_buf   <= '0;
      merged    <= '0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wd    <= '0;
      align_err <= 1'b0;
    end else if (clk_enable) begin
      state <= next_state;
      if (capture) begin
        rmw_buf  <= bus.mem_readdata;
        lat_addr <= bus.cpu_address[31:2];
        lat_be   <= bus.cpu_byteenable;
        lat_wd   <= bus.cpu_writedata;
      end
      if (state == RMW_RD) merged <= merge_word;
      if (state == IDLE && (bus.cpu_read || bus.cpu_write) && bus.cpu_address[1:0] != 2'b00)
        align_err <= 1'b1;
    end
  end

  // Strobes are masked by reset directly, and the write strobe by clk_enable so a frozen
  // write cycle never commits more than once.
  assign bus.mem_read      = fsm_read & reset;
  assign bus.mem_write     = fsm_write & clk_enable & reset;
  assign bus.cpu_stall     = fsm_stall & reset;
  assign bus.mem_address   = addr_out;
  assign bus.mem_writedata = wdata_out;
  assign bus.cpu_readdata  = swap(bus.mem_readdata);

endmodule

// File: tb/tb_mips_dmem_rmw_ctrl.sv
// Bench for mips_dmem_rmw_ctrl: acts as CPU and word RAM, compares against a byte-lane
// model of memory kept in register order.
module tb_mips_dmem_rmw_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic clk_enable;
  logic align_err;

  mips_dmem_rmw_ctrl_if bus();

  mips_dmem_rmw_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [64];
  logic [31:0] model_mem [64];
  int total = 0;
  int bad = 0;
  int wr_count = 0;

  assign bus.mem_readdata = ram[bus.mem_address[7:2]];

  always @(posedge clk) begin
    if (bus.mem_write === 1'b1) begin
      ram[bus.mem_address[7:2]] = bus.mem_writedata;
      wr_count++;
    end
  end

  function automatic logic [31:0] to_mem_order(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1)
      check_output("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
  end

  task automatic apply_load(input logic [31:0] addr);
    @(negedge clk);
    bus.cpu_address = addr;
    bus.cpu_read    = 1'b1;
    bus.cpu_write   = 1'b0;
    #1;
    check_output("load_stall", 32'(bus.cpu_stall), 32'd0);
    check_output("load_mem_read", 32'(bus.mem_read), 32'd1);
    check_output("load_addr", bus.mem_address, {addr[31:2], 2'b00});
    check_output("load_data", bus.cpu_readdata, model_mem[addr[7:2]]);
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wd, input int freeze);
    int stalls;
    int wr_before;
    int exp_stalls;
    logic [31:0] new_w;
    new_w = model_mem[addr[7:2]];
    for (int b = 0; b < 4; b++) if (be[b]) new_w[8*b +: 8] = wd[8*b +: 8];
    exp_stalls = (be == 4'hF || be == 4'h0) ? 0 : 2;
    wr_before  = wr_count;
    @(negedge clk);
    bus.cpu_address    = addr;
    bus.cpu_byteenable = be;
    bus.cpu_writedata  = wd;
    bus.cpu_write      = 1'b1;
    bus.cpu_read       = 1'($urandom_range(0, 1));
    #1;
    stalls = 0;
    while (bus.cpu_stall && stalls < 8) begin
      check_output("rmw_no_write", 32'(bus.mem_write), 32'd0);
      check_output("rmw_read_phase", 32'(bus.mem_read), 32'(stalls == 0));
      stalls++;
      @(negedge clk);
      if (stalls == 1) begin
        bus.cpu_writedata  = $urandom;
        bus.cpu_byteenable = 4'($urandom);
        bus.cpu_address    = 32'h100 + 32'($urandom_range(0, 63) << 2);
        if (freeze > 0) begin
          clk_enable = 1'b0;
          repeat (freeze) begin
            @(negedge clk);
            #1;
            check_output("freeze_stall", 32'(bus.cpu_stall), 32'd1);
            check_output("freeze_no_write", 32'(bus.mem_write), 32'd0);
          end
          clk_enable = 1'b1;
        end
      end
      #1;
    end
    check_output("stall_cycles", 32'(stalls), 32'(exp_stalls));
    if (be != 4'h0) begin
      check_output("store_mem_write", 32'(bus.mem_write), 32'd1);
      check_output("store_mem_read", 32'(bus.mem_read), 32'd0);
      check_output("store_wdata", bus.mem_writedata, to_mem_order(new_w));
      check_output("store_addr", bus.mem_address, {addr[31:2], 2'b00});
    end else begin
      check_output("nostore_write", 32'(bus.mem_write), 32'd0);
      check_output("nostore_read", 32'(bus.mem_read), 32'd0);
    end
    @(negedge clk);
    bus.cpu_write = 1'b0;
    bus.cpu_read  = 1'b0;
    check_output("write_count", 32'(wr_count - wr_before), 32'(be != 4'h0));
    model_mem[addr[7:2]] = new_w;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wr_before;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      ram[i]       = $urandom;
      model_mem[i] = 32'h0;
      for (int b = 0; b < 4; b++) model_mem[i][8*b +: 8] = ram[i][8*(3-b) +: 8];
    end
    reset              = 1'b1;
    clk_enable         = 1'b1;
    bus.cpu_address    = 32'h100;
    bus.cpu_read       = 1'b1;
    bus.cpu_write      = 1'b0;
    bus.cpu_byteenable = 4'h0;
    bus.cpu_writedata  = 32'h0;

    #2 reset = 1'b0;
    #1;
    check_output("reset_stall", 32'(bus.cpu_stall), 32'd0);
    check_output("reset_mem_read", 32'(bus.mem_read), 32'd0);
    check_output("reset_mem_write", 32'(bus.mem_write), 32'd0);
    check_output("reset_align_err", 32'(align_err), 32'd0);
    bus.cpu_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_output("idle_read", 32'(bus.mem_read), 32'd0);
    check_output("idle_write", 32'(bus.mem_write), 32'd0);
    check_output("idle_stall", 32'(bus.cpu_stall), 32'd0);

    apply_stimulus(32'h100, 4'b1111, 32'h12345678, 0);
    check_output("full_store_ram", ram[0], 32'h78563412);
    apply_load(32'h100);
    check_output("load_after_store", bus.cpu_readdata, 32'h12345678);

    ram[1]       = 32'h44332211;
    model_mem[1] = 32'h11223344;
    apply_stimulus(32'h104, 4'b0001, 32'h000000AA, 0);
    check_output("store_byte_ram", ram[1], 32'hAA332211);

    ram[2]       = 32'h44332211;
    model_mem[2] = 32'h11223344;
    apply_stimulus(32'h108, 4'b1100, 32'hBEEF0000, 0);
    apply_load(32'h108);
    check_output("store_half_read", bus.cpu_readdata, 32'hBEEF3344);

    apply_stimulus(32'h10C, 4'b0000, $urandom, 0);

    wr_before = wr_count;
    @(negedge clk);
    bus.cpu_address    = 32'h110;
    bus.cpu_byteenable = 4'b0011;
    bus.cpu_writedata  = $urandom;
    bus.cpu_write      = 1'b1;
    bus.cpu_read       = 1'b0;
    #1;
    check_output("abort_first_stall", 32'(bus.cpu_stall), 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_output("abort_stall", 32'(bus.cpu_stall), 32'd0);
    check_output("abort_write", 32'(bus.mem_write), 32'd0);
    check_output("abort_read", 32'(bus.mem_read), 32'd0);
    bus.cpu_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("abort_write_count", 32'(wr_count - wr_before), 32'd0);
    apply_load(32'h110);

    apply_load(32'h102);
    check_output("misalign_before_edge", 32'(align_err), 32'd0);
    check_output("misalign_addr", bus.mem_address, 32'h100);
    @(negedge clk);
    bus.cpu_read = 1'b0;
    #1;
    check_output("misalign_flag", 32'(align_err), 32'd1);

    apply_stimulus(32'h114, 4'b0110, $urandom, 3);
    check_output("align_err_held", 32'(align_err), 32'd1);

    for (int n = 0; n < 24; n++) begin
      a = 32'h100 + 32'($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 1) == 0) apply_load(a);
      else apply_stimulus(a, 4'($urandom_range(0, 15)), $urandom, 0);
    end
    @(negedge clk);
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    #1;
    check_output("align_err_final", 32'(align_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
